jtpang_busarb: RTL and testbench
================================

JTPANG_BUSARB -- requirements
Module: jtpang_busarb

Interface
REQ-001 SHALL have parameter GRANT_DLY, default 2: cen_in ticks of idle bus required before the grant.
REQ-002 SHALL have parameter MAXHOLD, default 1023: maximum cen_in ticks a grant may last.
REQ-003 SHALL have parameter DMA_MSB, default 3'b110: upper VRAM address bits applied during DMA.
REQ-004 SHALL have a single clock: clk  in  1  system clock (48 MHz domain).
REQ-005 SHALL have a synchronous, active-high reset: rst  in  1  reset.
REQ-006 SHALL have port cen_in  in  1  raw CPU clock enable.
REQ-007 SHALL have port cpu_cen  out  1  gated CPU clock enable.
REQ-008 SHALL have port mreq_n  in  1  CPU memory request.
REQ-009 SHALL have port iorq_n  in  1  CPU I/O request.
REQ-010 SHALL have port busrq  in  1  DMA bus request, active high.
REQ-011 SHALL have port busak_n  out  1  bus acknowledge, active low.
REQ-012 SHALL have port cpu_addr  in  12  CPU address.
REQ-013 SHALL have port cpu_vram_cs  in  1  CPU VRAM select.
REQ-014 SHALL have port wr_n  in  1  CPU write strobe.
REQ-015 SHALL have port dma_addr  in  9  DMA read address.
REQ-016 SHALL have port vram_addr  out  12  muxed VRAM address.
REQ-017 SHALL have port vram_cs  out  1  muxed VRAM select.
REQ-018 SHALL have port vram_we  out  1  VRAM write enable.
REQ-019 SHALL have port timeout  out  1  sticky watchdog flag.

Function
REQ-020 SHALL implement the states IDLE, WAIT_BUS, SETTLE, GRANT and RELEASE.
REQ-021 SHALL, in IDLE, move to WAIT_BUS on the clk edge where busrq=1.
REQ-022 SHALL, in WAIT_BUS, pass cen_in to cpu_cen and move to SETTLE at a cen_in tick sampling mreq_n=1 and iorq_n=1.
REQ-023 SHALL, in SETTLE, force cpu_cen=0, count cen_in ticks, and move to GRANT after GRANT_DLY ticks; with GRANT_DLY=0 it SHALL go to GRANT on the next clk.
REQ-024 SHALL drive busak_n=0 only in GRANT; the registered output SHALL change on the clk edge of the state entry.
REQ-025 SHALL, in GRANT, keep cpu_cen=0 and increment a 10-bit hold counter on each cen_in tick.
REQ-026 SHALL go from GRANT to RELEASE on the first clk edge where busrq=0.
REQ-027 SHALL go from GRANT to RELEASE when the hold counter reaches MAXHOLD, and SHALL set timeout=1 in that case.
REQ-028 SHALL, in RELEASE, keep busak_n=1 and cpu_cen=0 until the next cen_in tick, then go to IDLE.
REQ-029 SHALL suppress that first tick, so the CPU resumes on the second cen_in tick.
REQ-030 SHALL pass cen_in to cpu_cen in IDLE.
REQ-031 SHALL, if busrq drops in WAIT_BUS or SETTLE, return to IDLE on the next clk without asserting busak_n and without a RELEASE stall.
REQ-032 SHALL, if busrq is still 1 on entering IDLE from RELEASE, restart arbitration via WAIT_BUS; back-to-back grants SHALL always have at least one CPU tick between them.
REQ-033 SHALL drive vram_addr combinationally as {DMA_MSB, dma_addr} in GRANT and as cpu_addr otherwise.
REQ-034 SHALL drive vram_cs combinationally as 1 in GRANT and as cpu_vram_cs otherwise.
REQ-035 SHALL drive vram_we = cpu_vram_cs & ~wr_n & ~grant, so DMA never writes VRAM.
REQ-036 SHALL clear the hold counter on every entry to GRANT.
REQ-037 SHALL keep timeout set once it is set, until reset.

Reset
REQ-038 SHALL, while rst=1 on a clk edge, set the state to IDLE, busak_n=1, timeout=0, and clear the hold and settle counters.
REQ-039 SHALL, on reset, release a grant in progress with busak_n=1 on that edge, and SHALL not use a RELEASE stall.
REQ-040 SHALL pass cen_in to cpu_cen combinationally during reset.

Verification
REQ-041 SHALL be verified as follows: cen_in every 6 clk, bus idle, busrq rises -> busak_n=0 after 2 cen_in ticks (GRANT_DLY=2), cpu_cen=0 throughout, vram_addr=0xC00|dma_addr.
REQ-042 SHALL be verified as follows: busrq rises while mreq_n=0 for 3 ticks -> cpu_cen keeps ticking 3 ticks, then SETTLE, busak_n=0 two ticks later.
REQ-043 SHALL be verified as follows: busrq drops during GRANT -> busak_n=1 next clk, first cen_in tick suppressed, cpu_cen resumes on second tick.
REQ-044 SHALL be verified as follows: busrq held high for 1100 cen_in ticks -> forced release after 1023 ticks, timeout=1, re-grant after one CPU tick.
REQ-045 SHALL be verified as follows: cpu_vram_cs=1, wr_n=0 during GRANT -> vram_we=0; the same write in IDLE -> vram_we=1 with vram_addr=cpu_addr.
REQ-046 SHALL be verified as follows: rst pulse in GRANT -> busak_n=1 and timeout=0 on the same edge, state IDLE, cpu_cen=cen_in.

Source files
------------

// File: rtl/jtpang_busarb.sv
// CPU/DMA VRAM bus arbiter: stalls the CPU clock enable, waits for an idle bus, then grants VRAM to DMA.
// Grant lands GRANT_DLY cen_in ticks after the bus is idle; release costs one suppressed CPU tick.
module jtpang_busarb #(
   parameter int         GRANT_DLY = 2,
   parameter int         MAXHOLD   = 1023,
   parameter logic [2:0] DMA_MSB   = 3'b110
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen_in,
   output logic        cpu_cen,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        busrq,
   output logic        busak_n,
   input  logic [11:0] cpu_addr,
   input  logic        cpu_vram_cs,
   input  logic        wr_n,
   input  logic [8:0]  dma_addr,
   output logic [11:0] vram_addr,
   output logic        vram_cs,
   output logic        vram_we,
   output logic        timeout
);

   localparam int             SW          = (GRANT_DLY > 1) ? $clog2(GRANT_DLY) : 1;
   localparam logic [SW-1:0]  SETTLE_LAST = SW'((GRANT_DLY > 0) ? GRANT_DLY - 1 : 0);
   localparam logic [9:0]     HOLD_MAX    = 10'(MAXHOLD);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BUS,
      SETTLE,
      GRANT,
      RELEASE
   } state_t;

   state_t          state;
   logic [SW-1:0]   settle_cnt;
   logic [9:0]      hold_cnt;
   logic            grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busak_n    <= 1'b1;
         timeout    <= 1'b0;
         settle_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (busrq) state <= WAIT_BUS;
            end
            WAIT_BUS: begin
               if (!busrq) begin
                  state <= IDLE;
               end else if (cen_in && mreq_n && iorq_n) begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               if (!busrq) begin
                  state      <= IDLE;
                  settle_cnt <= '0;
               end else if (GRANT_DLY == 0 || (cen_in && settle_cnt == SETTLE_LAST)) begin
                  state      <= GRANT;
                  busak_n    <= 1'b0;
                  hold_cnt   <= '0;
                  settle_cnt <= '0;
               end else if (cen_in) begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            GRANT: begin
               // A watchdog expiry wins over a simultaneous busrq drop so it is never missed
               if (hold_cnt == HOLD_MAX) begin
                  state   <= RELEASE;
                  busak_n <= 1'b1;
                  timeout <= 1'b1;
               end else if (!busrq) begin
                  state   <= RELEASE;
                  busak_n <= 1'b1;
               end else if (cen_in) begin
                  hold_cnt <= hold_cnt + 10'd1;
               end
            end
            RELEASE: begin
               if (cen_in) state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               busak_n <= 1'b1;
            end
         endcase
      end
   end

   assign grant     = (state == GRANT);
   // RELEASE swallows one tick here; IDLE then lets the next one through
   assign cpu_cen   = cen_in & (rst | state == IDLE | state == WAIT_BUS);
   assign vram_addr = grant ? {DMA_MSB, dma_addr} : cpu_addr;
   assign vram_cs   = grant | cpu_vram_cs;
   assign vram_we   = cpu_vram_cs & ~wr_n & ~grant;

endmodule

// File: tb/tb_jtpang_busarb.sv
// Directed bench for jtpang_busarb: cen_in pulses one clk in every six.
module tb_jtpang_busarb;

   logic        clk = 1'b0;
   logic        rst;
   logic        cen_in;
   logic        cpu_cen;
   logic        mreq_n;
   logic        iorq_n;
   logic        busrq;
   logic        busak_n;
   logic [11:0] cpu_addr;
   logic        cpu_vram_cs;
   logic        wr_n;
   logic [8:0]  dma_addr;
   logic [11:0] vram_addr;
   logic        vram_cs;
   logic        vram_we;
   logic        timeout;

   int n_asrt = 0;
   int n_fail = 0;
   int phase  = 0;
   int n_tick;
   int n_cpu;

   jtpang_busarb #(
      .GRANT_DLY (2),
      .MAXHOLD   (1023),
      .DMA_MSB   (3'b110)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cen_in      (cen_in),
      .cpu_cen     (cpu_cen),
      .mreq_n      (mreq_n),
      .iorq_n      (iorq_n),
      .busrq       (busrq),
      .busak_n     (busak_n),
      .cpu_addr    (cpu_addr),
      .cpu_vram_cs (cpu_vram_cs),
      .wr_n        (wr_n),
      .dma_addr    (dma_addr),
      .vram_addr   (vram_addr),
      .vram_cs     (vram_cs),
      .vram_we     (vram_we),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clk; cen_in for the following edge is set 1 after the edge, outputs settle by +2
   task automatic adv();
      @(posedge clk);
      #1;
      phase  = (phase == 5) ? 0 : phase + 1;
      cen_in = (phase == 5);
      #1;
   endtask

   // Stops with cen_in high, i.e. just before the edge that samples the next tick
   task automatic wait_cen();
      for (int i = 0; i < 8; i++) begin
         adv();
         if (cen_in) break;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cen_in = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1; busrq = 1'b0;
      cpu_addr = 12'h000; cpu_vram_cs = 1'b0; wr_n = 1'b1; dma_addr = 9'h000;

      // Reset state
      repeat (3) adv();
      check("rst_busak_n", busak_n, 1);
      check("rst_timeout", timeout, 0);
      cen_in = 1'b1; #1;
      check("rst_cen_pass_hi", cpu_cen, 1);
      cen_in = 1'b0; #1;
      check("rst_cen_pass_lo", cpu_cen, 0);
      phase = 0;
      rst   = 1'b0;

      // CPU write in IDLE reaches VRAM
      cpu_addr = 12'h345; cpu_vram_cs = 1'b1; wr_n = 1'b0; #1;
      check("idle_we", vram_we, 1);
      check("idle_addr", vram_addr, 12'h345);
      check("idle_cs", vram_cs, 1);
      cpu_vram_cs = 1'b0; wr_n = 1'b1;
      wait_cen();
      check("idle_cen_pass", cpu_cen, 1);
      adv();

      // Idle bus: grant two ticks after the bus-idle tick
      busrq = 1'b1; dma_addr = 9'h1A5;
      adv();
      wait_cen();
      check("wb_cen_pass", cpu_cen, 1);
      adv();
      wait_cen();
      check("settle1_cen_gated", cpu_cen, 0);
      adv();
      check("settle1_busak_n", busak_n, 1);
      wait_cen();
      check("settle2_cen_gated", cpu_cen, 0);
      adv();
      check("grant1_busak_n", busak_n, 0);
      check("grant_vram_addr", vram_addr, 12'hDA5);
      check("grant_vram_cs", vram_cs, 1);
      cpu_vram_cs = 1'b1; wr_n = 1'b0; #1;
      check("grant_no_we", vram_we, 0);
      wait_cen();
      check("grant_cen_gated", cpu_cen, 0);
      adv();
      cpu_vram_cs = 1'b0; wr_n = 1'b1;

      // busrq drop: release next clk, first tick swallowed, second passes
      busrq = 1'b0;
      adv();
      check("drop_busak_n", busak_n, 1);
      wait_cen();
      check("release_tick_supp", cpu_cen, 0);
      adv();
      wait_cen();
      check("release_2nd_tick", cpu_cen, 1);
      adv();

      // Busy bus: CPU keeps running while mreq_n is low
      mreq_n = 1'b0; busrq = 1'b1;
      adv();
      for (int k = 0; k < 3; k++) begin
         wait_cen();
         check("busy_cen_pass", cpu_cen, 1);
         adv();
      end
      check("busy_busak_n", busak_n, 1);
      mreq_n = 1'b1;
      wait_cen();
      check("busy_idle_tick", cpu_cen, 1);
      adv();
      wait_cen();
      check("busy_settle1", cpu_cen, 0);
      adv();
      check("busy_settle1_busak_n", busak_n, 1);
      wait_cen();
      check("busy_settle2", cpu_cen, 0);
      adv();
      check("busy_grant_busak_n", busak_n, 0);

      // Held request: watchdog releases after 1023 ticks
      n_tick = 0; n_cpu = 0;
      for (int i = 0; i < 7000 && busak_n == 1'b0; i++) begin
         if (cen_in)  n_tick++;
         if (cpu_cen) n_cpu++;
         adv();
      end
      check("hold_released", busak_n, 1);
      check("hold_ticks", n_tick, 1023);
      check("hold_cpu_ticks", n_cpu, 0);
      check("hold_timeout", timeout, 1);

      // Still requesting: re-grant after exactly one CPU tick
      n_cpu = 0;
      for (int i = 0; i < 200 && busak_n == 1'b1; i++) begin
         if (cpu_cen) n_cpu++;
         adv();
      end
      check("regrant_busak_n", busak_n, 0);
      check("regrant_cpu_ticks", n_cpu, 1);
      check("timeout_sticky", timeout, 1);

      // Reset during a grant
      cpu_addr = 12'h0AB;
      wait_cen();
      rst = 1'b1; busrq = 1'b0; #1;
      check("rst_grant_cen", cpu_cen, 1);
      adv();
      check("rst_grant_busak_n", busak_n, 1);
      check("rst_grant_timeout", timeout, 0);
      check("rst_grant_addr", vram_addr, 12'h0AB);
      rst = 1'b0;
      wait_cen();
      check("post_rst_cen", cpu_cen, 1);
      adv();

      // Abort in SETTLE: back to IDLE with no grant and no stall
      busrq = 1'b1;
      adv();
      wait_cen();
      adv();
      busrq = 1'b0;
      adv();
      check("abort_busak_n", busak_n, 1);
      wait_cen();
      check("abort_no_stall", cpu_cen, 1);
      adv();
      check("abort_still_idle", busak_n, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
